instr_mem_ctrl: RTL and testbench
=================================

Name: instr_mem_ctrl

Overview:
- Parametrised, clocked instruction memory for the multi-cycle MIPS32 core.
- Replaces the fixed 512x32 asynchronous tristate ROM.
- Adds a program-load write port, a request/acknowledge read handshake with configurable wait states, and fault reporting for misaligned or out-of-range fetches.
- Sits between the control unit's instruction-fetch state and the program store. The testbench or boot loader fills the array through the load port.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 11, byte-address width of the fetch port; word index is rd_addr[ADDR_W-1:2]
DEPTH, 512, number of implemented words; legal range 1..2^(ADDR_W-2)
WAIT_STATES, 1, extra cycles before read data returns; legal range 0..15

Ports:
clk  in  1  rising-edge clock
nrst  in  1  reset, synchronous, active-low
nce  in  1  chip enable, active-low; must be low for a fetch to be accepted or to continue
rd_req  in  1  fetch request; level signal, held by the requester until rd_ack
rd_addr  in  ADDR_W  byte address of the fetch
rd_data  out  DATA_W  fetched word, registered
rd_ack  out  1  one-cycle pulse; rd_data and rd_fault are valid in this cycle
rd_fault  out  1  fetch error flag, qualified by rd_ack
busy  out  1  high whenever the FSM is not in IDLE
ld_we  in  1  program-load write strobe
ld_addr  in  ADDR_W-2  word index for the load write
ld_data  in  DATA_W  word to be written

Behaviour:
- Reset (nrst low at a rising edge):
  - FSM goes to IDLE.
  - rd_data=0, rd_ack=0, rd_fault=0, busy=0, wait counter=0.
  - Memory array contents are NOT cleared; reset mid-fetch aborts the fetch with no ack.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ld_we=1 and ld_addr<DEPTH: write mem[ld_addr]=ld_data at the edge.
  - ld_we=1 and ld_addr>=DEPTH: write silently dropped.
  - ld_we=1 with nce=0 and rd_req=1 in the same cycle: the load has priority and the request is not accepted. The requester keeps rd_req high and it is accepted on a later edge.
  - Otherwise, nce=0 and rd_req=1: accept the request and latch rd_addr.
    - WAIT_STATES=0: go to RESP.
    - WAIT_STATES>0: go to WAIT with counter=WAIT_STATES-1.
- WAIT:
  - Counter decrements each cycle; on counter=0, go to RESP.
  - nce going high in WAIT aborts the fetch: back to IDLE, no ack, outputs unchanged.
  - ld_we is ignored in WAIT and RESP.
- RESP (exactly one cycle):
  - rd_ack=1.
  - Misaligned address (latched addr[1:0]!=0): rd_fault=1, rd_data=0.
  - Out-of-range address (word index>=DEPTH): rd_fault=1, rd_data=0.
  - Otherwise: rd_fault=0, rd_data=mem[word index].
  - Next state is IDLE unconditionally.
- Timing:
  - rd_ack is high in the cycle WAIT_STATES+1 edges after the accept edge.
  - Minimum accept-to-accept spacing is WAIT_STATES+2 cycles.
  - rd_req still high in the cycle after ack is treated as a new request.
- rd_data and rd_fault hold their values after ack until the next RESP or reset. rd_ack returns to 0 after one cycle.
- Address is latched at accept; changes on rd_addr during WAIT have no effect.
- Read-after-load: a word written at edge N is returned by any fetch accepted at edge N+1 or later.
- Reads of never-written in-range words return unspecified data; benches must load before reading.

Test Plan:
- Load & fetch (defaults, WAIT_STATES=1):
  - Stimulus: load mem[0]=32'h20010008 and mem[1]=32'h00010C00; request rd_addr=0 at edge T, then rd_addr=4.
  - Required: rd_ack high exactly in cycle T+2 with rd_data=32'h20010008, rd_fault=0. Second fetch returns 32'h00010C00; accepts are spaced 3 cycles apart.
- Zero wait (WAIT_STATES=0), back-to-back:
  - Stimulus: rd_req held high across addresses 0x0, 0x4, 0x8.
  - Required: three acks, each one cycle wide, spaced 2 cycles apart, with correct words.
- Faults:
  - rd_addr=0x006 -> rd_ack with rd_fault=1, rd_data=0.
  - DEPTH=16, rd_addr=0x040 -> rd_fault=1, rd_data=0.
  - Load to ld_addr=20 at DEPTH=16 -> a later read of word 4 is unchanged.
- Load/read collision:
  - Stimulus: ld_we=1 (addr 2, 32'hDEADBEEF) in the same cycle as rd_req for addr 0x8.
  - Required: load wins; the request is accepted next edge and returns 32'hDEADBEEF. ld_we asserted while busy=1 leaves memory unchanged.
- Abort:
  - nce raised during WAIT (WAIT_STATES=3) -> no rd_ack, busy=0 next cycle, rd_data keeps its previous value.
  - nrst low mid-WAIT -> all outputs 0. Memory still holds the loaded words, confirmed by a post-reset fetch.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Clocked instruction memory for the multi-cycle MIPS32 core: program-load port,
// req/ack fetch with configurable wait states, and misaligned/out-of-range fault flag.
module instr_mem_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_nce,
  input  logic                i_rd_req,
  input  logic [ADDR_W-1:0]   i_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_ack,
  output logic                o_rd_fault,
  output logic                o_busy,
  input  logic                i_ld_we,
  input  logic [ADDR_W-3:0]   i_ld_addr,
  input  logic [DATA_W-1:0]   i_ld_data
);

  localparam int unsigned WORD_W = ADDR_W - 2;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_ack;
  logic              r_rd_fault;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [1:0]        w_next_state;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_ld_ok;
  logic              w_accept;
  logic [WORD_W-1:0] w_word;
  logic [MEM_AW-1:0] w_rd_idx;
  logic              w_oor;
  logic              w_fault;

  // A load in IDLE always wins over a simultaneous fetch request
  assign w_ld_ok  = (r_state == S_IDLE) && i_ld_we && (32'(i_ld_addr) < DEPTH);
  assign w_accept = (r_state == S_IDLE) && !i_ld_we && !i_nce && i_rd_req;

  assign w_word   = r_addr[ADDR_W-1:2];
  assign w_rd_idx = r_addr[MEM_AW+1:2];
  assign w_oor    = 32'(w_word) >= DEPTH;
  assign w_fault  = (r_addr[1:0] != 2'b00) || w_oor;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_STATES == 0) begin
            w_next_state = S_RESP;
          end else begin
            w_next_state = S_WAIT;
            w_cnt_next   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (i_nce)              w_next_state = S_IDLE;
        else if (r_cnt == '0)   w_next_state = S_RESP;
        else                    w_cnt_next   = r_cnt - CNT_W'(1);
      end
      S_RESP:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Response registers: ack/data/fault are produced on the edge that leaves RESP
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_cnt      <= '0;
      r_addr     <= '0;
      r_rd_data  <= '0;
      r_rd_ack   <= 1'b0;
      r_rd_fault <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_busy   <= (w_next_state != S_IDLE);
      r_rd_ack <= (r_state == S_RESP);
      if (w_accept) r_addr <= i_rd_addr;
      if (r_state == S_RESP) begin
        r_rd_fault <= w_fault;
        r_rd_data  <= w_fault ? '0 : r_mem[w_rd_idx];
      end
    end
  end

  // Program store is not touched by reset
  always_ff @(posedge i_clk) begin
    if (w_ld_ok) r_mem[i_ld_addr[MEM_AW-1:0]] <= i_ld_data;
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_ack   = r_rd_ack;
  assign o_rd_fault = r_rd_fault;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl: three instances (WAIT=1, DEPTH=16/WAIT=0, WAIT=3)
// sharing load/fetch inputs, each selected for fetches by its own chip enable.
module tb_instr_mem_ctrl;

  logic        clk = 1'b0;
  logic        nrst, rd_req, ld_we;
  logic [10:0] rd_addr;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  logic        nce_a, nce_b, nce_c;

  logic [31:0] a_data, b_data, c_data;
  logic        a_ack, b_ack, c_ack;
  logic        a_fault, b_fault, c_fault;
  logic        a_busy, b_busy, c_busy;

  logic [1:0]  sel;
  logic [31:0] sel_data;
  logic        sel_ack, sel_fault, sel_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(512), .WAIT_STATES(1)) u_dut_a (
    .i_clk(clk), .i_nrst(nrst), .i_nce(nce_a), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_data(a_data), .o_rd_ack(a_ack), .o_rd_fault(a_fault), .o_busy(a_busy),
    .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  instr_mem_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(16), .WAIT_STATES(0)) u_dut_b (
    .i_clk(clk), .i_nrst(nrst), .i_nce(nce_b), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_data(b_data), .o_rd_ack(b_ack), .o_rd_fault(b_fault), .o_busy(b_busy),
    .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  instr_mem_ctrl #(.DATA_W(32), .ADDR_W(11), .DEPTH(512), .WAIT_STATES(3)) u_dut_c (
    .i_clk(clk), .i_nrst(nrst), .i_nce(nce_c), .i_rd_req(rd_req), .i_rd_addr(rd_addr),
    .o_rd_data(c_data), .o_rd_ack(c_ack), .o_rd_fault(c_fault), .o_busy(c_busy),
    .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data));

  always_comb begin
    sel_data = a_data; sel_ack = a_ack; sel_fault = a_fault; sel_busy = a_busy;
    case (sel)
      2'd1: begin sel_data = b_data; sel_ack = b_ack; sel_fault = b_fault; sel_busy = b_busy; end
      2'd2: begin sel_data = c_data; sel_ack = c_ack; sel_fault = c_fault; sel_busy = c_busy; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nce(input int inst, input logic v);
    case (inst)
      0: nce_a = v;
      1: nce_b = v;
      default: nce_c = v;
    endcase
  endtask

  task automatic load(input logic [8:0] a, input logic [31:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  // Single isolated fetch: ack expected exactly ws+1 edges after the accept edge
  task automatic fetch(input int inst, input logic [10:0] addr, input int ws,
                       input logic [31:0] exp_d, input logic exp_f, input string tag);
    sel = 2'(inst);
    set_nce(inst, 1'b0);
    rd_addr = addr; rd_req = 1'b1;
    step();
    for (int i = 0; i <= ws; i++) begin
      chk({tag, "_early_ack"}, 32'(sel_ack), 32'd0);
      step();
    end
    rd_req = 1'b0;
    chk({tag, "_ack"},   32'(sel_ack),   32'd1);
    chk({tag, "_data"},  sel_data,       exp_d);
    chk({tag, "_fault"}, 32'(sel_fault), 32'(exp_f));
    set_nce(inst, 1'b1);
    step();
    chk({tag, "_pulse"}, 32'(sel_ack), 32'd0);
    chk({tag, "_hold"},  sel_data,     exp_d);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; rd_req = 1'b0; ld_we = 1'b0; rd_addr = '0; ld_addr = '0; ld_data = '0;
    nce_a = 1'b1; nce_b = 1'b1; nce_c = 1'b1; sel = 2'd0;
    step(); step();
    chk("rst_ack",   32'(a_ack),   32'd0);
    chk("rst_data",  a_data,       32'd0);
    chk("rst_fault", 32'(a_fault), 32'd0);
    chk("rst_busy",  32'(a_busy),  32'd0);
    nrst = 1'b1;
    step();

    load(9'd0,  32'h20010008);
    load(9'd1,  32'h00010C00);
    load(9'd2,  32'h11111111);
    load(9'd4,  32'h44444444);
    load(9'd20, 32'hBADBAD20);

    // Defaults (WAIT=1): held request re-accepted in the ack cycle, 3-cycle spacing
    sel = 2'd0; nce_a = 1'b0; rd_addr = 11'h000; rd_req = 1'b1;
    step();
    chk("t1_busy", 32'(a_busy), 32'd1);
    chk("t1_ack0", 32'(a_ack),  32'd0);
    step();
    chk("t1_ack1", 32'(a_ack),  32'd0);
    step();
    chk("t1_ack2",   32'(a_ack),   32'd1);
    chk("t1_data2",  a_data,       32'h20010008);
    chk("t1_fault2", 32'(a_fault), 32'd0);
    rd_addr = 11'h004;
    step();
    chk("t1_pulse", 32'(a_ack), 32'd0);
    chk("t1_hold",  a_data,     32'h20010008);
    chk("t1_busy2", 32'(a_busy), 32'd1);
    step();
    chk("t1_ack4", 32'(a_ack), 32'd0);
    step();
    chk("t1_ack5",  32'(a_ack), 32'd1);
    chk("t1_data5", a_data,     32'h00010C00);
    rd_req = 1'b0; nce_a = 1'b1;
    step();
    chk("t1_idle_ack",  32'(a_ack),  32'd0);
    chk("t1_idle_busy", 32'(a_busy), 32'd0);

    // Zero wait states, request held across three addresses
    sel = 2'd1; nce_b = 1'b0; rd_addr = 11'h000; rd_req = 1'b1;
    step();
    chk("t2_ack0", 32'(b_ack), 32'd0);
    step();
    chk("t2_ack1",  32'(b_ack), 32'd1);
    chk("t2_data1", b_data,     32'h20010008);
    rd_addr = 11'h004;
    step();
    chk("t2_ack2", 32'(b_ack), 32'd0);
    step();
    chk("t2_ack3",  32'(b_ack), 32'd1);
    chk("t2_data3", b_data,     32'h00010C00);
    rd_addr = 11'h008;
    step();
    chk("t2_ack4", 32'(b_ack), 32'd0);
    step();
    chk("t2_ack5",  32'(b_ack), 32'd1);
    chk("t2_data5", b_data,     32'h11111111);
    rd_req = 1'b0; nce_b = 1'b1;
    step();
    chk("t2_ack6", 32'(b_ack), 32'd0);

    // Faults and range checks
    fetch(0, 11'h006, 1, 32'h00000000, 1'b1, "mis_a");
    fetch(1, 11'h040, 0, 32'h00000000, 1'b1, "oor_b");
    fetch(1, 11'h010, 0, 32'h44444444, 1'b0, "alias_b");
    fetch(0, 11'h050, 1, 32'hBADBAD20, 1'b0, "w20_a");

    // Load and request in the same cycle: load first, accept on the next edge
    sel = 2'd0;
    ld_we = 1'b1; ld_addr = 9'd2; ld_data = 32'hDEADBEEF;
    nce_a = 1'b0; rd_addr = 11'h008; rd_req = 1'b1;
    step();
    ld_we = 1'b0;
    chk("col_busy0", 32'(a_busy), 32'd0);
    step();
    chk("col_busy1", 32'(a_busy), 32'd1);
    step();
    chk("col_ack0", 32'(a_ack), 32'd0);
    step();
    chk("col_ack1",  32'(a_ack), 32'd1);
    chk("col_data",  a_data,     32'hDEADBEEF);
    rd_req = 1'b0; nce_a = 1'b1;
    step();

    // Load while busy must be ignored by that instance
    nce_a = 1'b0; rd_addr = 11'h004; rd_req = 1'b1;
    step();
    chk("ldb_busy", 32'(a_busy), 32'd1);
    ld_we = 1'b1; ld_addr = 9'd1; ld_data = 32'hCAFEF00D;
    step();
    ld_we = 1'b0;
    chk("ldb_ack0", 32'(a_ack), 32'd0);
    step();
    chk("ldb_ack1", 32'(a_ack), 32'd1);
    chk("ldb_data", a_data,     32'h00010C00);
    rd_req = 1'b0; nce_a = 1'b1;
    step();

    // Abort by chip enable during WAIT (WAIT=3)
    fetch(2, 11'h000, 3, 32'h20010008, 1'b0, "pre_c");
    sel = 2'd2; nce_c = 1'b0; rd_addr = 11'h008; rd_req = 1'b1;
    step();
    chk("ab_busy0", 32'(c_busy), 32'd1);
    step();
    nce_c = 1'b1;
    step();
    chk("ab_busy", 32'(c_busy), 32'd0);
    chk("ab_ack",  32'(c_ack),  32'd0);
    chk("ab_data", c_data,      32'h20010008);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ab_noack", 32'(c_ack), 32'd0);
    end
    rd_req = 1'b0;
    chk("ab_hold", c_data, 32'h20010008);

    // Reset mid-WAIT clears outputs but not the program store
    nce_c = 1'b0; rd_addr = 11'h004; rd_req = 1'b1;
    step();
    step();
    nrst = 1'b0; rd_req = 1'b0; nce_c = 1'b1;
    step();
    chk("rs_ack",   32'(c_ack),   32'd0);
    chk("rs_data",  c_data,       32'd0);
    chk("rs_fault", 32'(c_fault), 32'd0);
    chk("rs_busy",  32'(c_busy),  32'd0);
    chk("rs_a_data", a_data,      32'd0);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rs_noack", 32'(c_ack), 32'd0);
    end
    fetch(2, 11'h008, 3, 32'hDEADBEEF, 1'b0, "post_c");
    fetch(2, 11'h000, 3, 32'h20010008, 1'b0, "post_c0");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
